// File: rtl/xor_parity_rx_if.sv
// Receive-side bundle for the XOR-parity serial link: serial line in, byte and status out.
// The receiver takes the master view; the byte consumer (and line driver) takes the slave view.
interface xor_parity_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/xor_parity_rx.sv
// UART-style frame receiver with XOR parity: start, DATA_BITS data (LSB first), parity, stop.
// Flags parity and framing errors alongside a one-cycle data_valid strobe.
module xor_parity_rx #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    xor_parity_rx_if.master  bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cyc_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic half_tick;
    logic bit_tick;
    logic last_bit;
    logic busy_c;
    logic start_ok;
    logic sample_data;
    logic sample_par;
    logic frame_done;

    assign half_tick = (cyc_cnt == CW'(HALF - 1));
    assign bit_tick  = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    // WAIT_HIGH keeps a line held low (or in break) from looking like a stream of start bits.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_HIGH: if (rx_s)      state_next = IDLE;
            IDLE:      if (!rx_s)     state_next = START;
            START:     if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (bit_tick && last_bit) state_next = PARITY;
            PARITY:    if (bit_tick)  state_next = STOP;
            STOP:      if (bit_tick)  state_next = rx_s ? IDLE : WAIT_HIGH;
            default:   state_next = WAIT_HIGH;
        endcase
    end

    always_comb begin
        busy_c      = 1'b0;
        start_ok    = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        frame_done  = 1'b0;
        case (state)
            START: begin
                busy_c   = 1'b1;
                start_ok = half_tick && !rx_s;
            end
            DATA: begin
                busy_c      = 1'b1;
                sample_data = bit_tick;
            end
            PARITY: begin
                busy_c     = 1'b1;
                sample_par = bit_tick;
            end
            STOP: begin
                busy_c     = 1'b1;
                frame_done = bit_tick;
            end
            default: ;
        endcase
    end

    // The cycle counter restarts at mid-start so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_meta <= bus.rx_in;
            rx_s    <= rx_meta;

            if (!busy_c) begin
                cyc_cnt <= '0;
            end else if ((state == START) ? half_tick : bit_tick) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end

            if (start_ok) begin
                bit_cnt <= '0;
                parity  <= (PARITY_ODD != 0);
            end else if (sample_data) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                parity  <= parity ^ rx_s;
            end else if (sample_par) begin
                parity  <= parity ^ rx_s;
            end

            valid_q <= frame_done;
            perr_q  <= frame_done & parity;
            ferr_q  <= frame_done & ~rx_s;
            if (frame_done) begin
                data_q <= shreg;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed bench for xor_parity_rx: frames are driven bit by bit, expectations queued,
// and a negedge monitor pops and checks each data_valid strobe including its arrival cycle.
module tb_xor_parity_rx;

    localparam int C    = 50;
    localparam int HALF = C / 2;
    localparam int DB   = 8;
    // Drive edge -> two synchroniser flops -> IDLE detect, then mid-start plus DB+2 bit times.
    localparam int LAT  = 3 + HALF + (DB + 2) * C;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic prev_valid;
    logic [7:0] last_data;

    xor_parity_rx_if #(.DATA_BITS(DB)) bus ();

    xor_parity_rx #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(DB),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        bus.rx_in = b;
        repeat (C) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                                 input logic exp_perr, input logic exp_ferr);
        exp_t e;
        e.data = d;
        e.perr = exp_perr;
        e.ferr = exp_ferr;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        sendBit(1'b0);
        for (int i = 0; i < DB; i++) sendBit(d[i]);
        sendBit(p);
        sendBit(s);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_out"},   32'(bus.data_out),   32'h0);
        checkOutput({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
        checkOutput({tag, "_parity_err"}, 32'(bus.parity_err), 32'h0);
        checkOutput({tag, "_frame_err"},  32'(bus.frame_err),  32'h0);
        checkOutput({tag, "_busy"},       32'(bus.busy),       32'h0);
    endtask

    initial begin
        prev_valid = 1'b0;
        last_data  = '0;
    end

    // Monitor: every strobe must match the head of the scoreboard, and flags must clear afterwards.
    always @(negedge clk) begin
        if (bus.data_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(bus.data_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("data_out",   32'(bus.data_out),   32'(e.data));
                checkOutput("parity_err", 32'(bus.parity_err), 32'(e.perr));
                checkOutput("frame_err",  32'(bus.frame_err),  32'(e.ferr));
                checkOutput("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (prev_valid) begin
            checkOutput("parity_err_clear", 32'(bus.parity_err), 32'h0);
            checkOutput("frame_err_clear",  32'(bus.frame_err),  32'h0);
            checkOutput("data_out_hold",    32'(bus.data_out),   32'(last_data));
        end
        prev_valid = bus.data_valid;
        last_data  = bus.data_out;
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.rx_in  = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        checkAllZero("reset");
        repeat (2 * C) tick();

        $display("[TB] clean frame 0xA5");
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        sendBit(1'b1);

        $display("[TB] parity error frame 0x01");
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        sendBit(1'b1);

        $display("[TB] framing error 0x3C then line held low");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.rx_in = 1'b0;
        repeat (20 * C) tick();
        bus.rx_in = 1'b1;
        repeat (2 * C) tick();
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        sendBit(1'b1);

        $display("[TB] both errors on 0x80");
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.rx_in = 1'b1;
        repeat (2 * C) tick();

        $display("[TB] 10-cycle glitch on idle line");
        c0 = cyc;
        bus.rx_in = 1'b0;
        repeat (10) tick();
        bus.rx_in = 1'b1;
        checkOutput("glitch_busy_high", 32'(bus.busy), 32'h1);
        while (cyc < c0 + 29) tick();
        checkOutput("glitch_busy_low", 32'(bus.busy), 32'h0);
        repeat (2 * C) tick();

        $display("[TB] back-to-back 0x00 0xFF 0x80");
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        sendBit(1'b1);

        $display("[TB] reset midway through 0x7E");
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'h7E;
            sendBit(d[i]);
        end
        checkOutput("midframe_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("midreset");
        bus.rx_in = 1'b1;
        repeat (3 * C) tick();
        applyStimulus(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        sendBit(1'b1);

        for (int i = 0; i < 2000 && sb.size() != 0; i++) tick();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
